mb_tx_flit_arb: RTL and testbench

Round-robin flit arbiter and handshake sequencer in front of the mainband transmitter. It shares the MB_TX flit input between `NUM_REQ` protocol-side requesters. It latches the winning requester's 64-byte flit and drives the transmitter's `valid`/`valid_ack` four-phase handshake, so requesters never touch that handshake themselves. It lives in the 100 MHz protocol clock domain, next to MB_TX in the logical PHY.

---
 rtl/mb_arb_pkg.sv | 14 +
 rtl/mb_sync2.sv | 23 ++
 rtl/mb_tx_flit_arb.sv | 148 ++++++++++++++
 tb/tb_mb_tx_flit_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_arb_pkg.sv
// Shared types for the mainband TX flit arbiter: flit layout and sequencer states.
package mb_arb_pkg;

  localparam int FLIT_BYTES = 64;

  typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mb_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module mb_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mb_tx_flit_arb.sv
// Round-robin flit arbiter and four-phase valid/valid_ack sequencer in front of MB_TX.
// Optional ack watchdog enabled by defining MB_TX_ARB_TIMEOUT_EN.
module mb_tx_flit_arb
  import mb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  flit_t [NUM_REQ-1:0]        req_data_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_REQ-1:0]         req_drop_o,
  output logic                       mb_valid_o,
  output flit_t                      mb_data_o,
  input  logic                       mb_valid_ack_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic [15:0]                flit_cnt_o,
  output logic                       err_timeout_o,
  output arb_state_e                 dbg_state_o
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mb_tx_flit_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a requester raises req_valid_i (level) with stable data and holds it
  // until a one-cycle req_ack_o (or req_drop_o) pulse; towards MB_TX mb_valid_o stays
  // high until ack_s rises, then falls, and no new flit starts until ack_s is low again.
  logic       ack_s;
  arb_state_e state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_nxt;
  logic           any_req;

  mb_sync2 #(.WIDTH(1)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (mb_valid_ack_i),
    .q       (ack_s)
  );

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    j       = 0;
    win_idx = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && req_valid_i[IDW'(j)]) begin
        any_req = 1'b1;
        win_idx = IDW'(j);
      end
    end
  end

  assign rr_nxt      = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
  assign dbg_state_o = state;

`ifdef MB_TX_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
`else
  assign req_drop_o    = '0;
  assign err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      mb_valid_o <= 1'b0;
      mb_data_o  <= '0;
      req_ack_o  <= '0;
      busy_o     <= 1'b0;
      grant_id_o <= '0;
      flit_cnt_o <= '0;
`ifdef MB_TX_ARB_TIMEOUT_EN
      to_cnt        <= '0;
      req_drop_o    <= '0;
      err_timeout_o <= 1'b0;
`endif
    end else begin
      req_ack_o <= '0;
`ifdef MB_TX_ARB_TIMEOUT_EN
      req_drop_o <= '0;
`endif
      case (state)
        IDLE: begin
          mb_valid_o <= 1'b0;
          // A stale-high ack from the previous transfer must clear before a new grant.
          if (any_req && !ack_s) begin
            mb_data_o  <= req_data_i[win_idx];
            grant_id_o <= win_idx;
            rr_ptr     <= rr_nxt;
            busy_o     <= 1'b1;
            state      <= SEND;
`ifdef MB_TX_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        SEND: begin
          if (ack_s) begin
            mb_valid_o <= 1'b0;
            req_ack_o  <= NUM_REQ'(1) << grant_id_o;
            flit_cnt_o <= flit_cnt_o + 16'd1;
            state      <= RELEASE;
          end else begin
`ifdef MB_TX_ARB_TIMEOUT_EN
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              mb_valid_o    <= 1'b0;
              req_drop_o    <= NUM_REQ'(1) << grant_id_o;
              err_timeout_o <= 1'b1;
              state         <= RELEASE;
            end else begin
              mb_valid_o <= 1'b1;
              to_cnt     <= to_cnt + TO_W'(1);
            end
`else
            mb_valid_o <= 1'b1;
`endif
          end
        end
        RELEASE: begin
          mb_valid_o <= 1'b0;
          if (!ack_s) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          mb_valid_o <= 1'b0;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_tx_flit_arb.sv
// Directed bench for mb_tx_flit_arb: per-cycle vector table plus hand sequences.
module tb_mb_tx_flit_arb;
  import mb_arb_pkg::*;

  localparam int NR = 4;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  flit_t [NR-1:0]    req_data;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     req_drop;
  logic              mb_valid;
  flit_t             mb_data;
  logic              mb_valid_ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic [15:0]       flit_cnt;
  logic              err_timeout;
  arb_state_e        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  flit_t flits[NR];

  mb_tx_flit_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ack_o      (req_ack),
    .req_drop_o     (req_drop),
    .mb_valid_o     (mb_valid),
    .mb_data_o      (mb_data),
    .mb_valid_ack_i (mb_valid_ack),
    .busy_o         (busy),
    .grant_id_o     (grant_id),
    .flit_cnt_o     (flit_cnt),
    .err_timeout_o  (err_timeout),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid    = '0;
    mb_valid_ack = 1'b0;
    reset_n      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_flit(input string name, input flit_t act, input flit_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got bytes[7:0]=0x%0h expected 0x%0h", name, act[7:0], exp[7:0]);
    end
  endtask

  function automatic flit_t str_flit(input string s);
    flit_t f;
    f = '0;
    for (int i = 0; i < s.len() && i < FLIT_BYTES; i++) f[i] = s[i];
    return f;
  endfunction

  function automatic flit_t pat_flit(input logic [7:0] seed);
    flit_t f;
    for (int i = 0; i < FLIT_BYTES; i++) f[i] = seed + 8'(i);
    return f;
  endfunction

  // driver: serve one flit from grant through release with bounded waits
  task automatic serve(input int exp_gid, input int exp_cnt);
    int n;
    n = 0;
    while (!mb_valid && n < 20) begin tick(); n++; end
    chk("serve_valid", 32'(mb_valid), 32'd1);
    chk("serve_gid", 32'(grant_id), 32'(exp_gid));
    chk_flit("serve_data", mb_data, flits[exp_gid]);
    mb_valid_ack = 1'b1;
    n = 0;
    while (req_ack == '0 && n < 10) begin tick(); n++; end
    chk("serve_ack", 32'(req_ack), 32'(1 << exp_gid));
    chk("serve_cnt", 32'(flit_cnt), 32'(exp_cnt));
    mb_valid_ack = 1'b0;
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    chk("serve_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic          ack;
    logic          exp_valid;
    logic [NR-1:0] exp_ack;
    logic          exp_busy;
    logic [1:0]    exp_gid;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    flit_t hold_a;
    int n;

    flits[0] = pat_flit(8'h10);
    flits[1] = pat_flit(8'h40);
    flits[2] = str_flit("Hello world, this is flit two");
    flits[3] = pat_flit(8'hC0);
    for (int i = 0; i < NR; i++) req_data[i] = flits[i];

    // single request from requester 2, then a stale-high ack holding off a grant
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd0};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd0};
    tbl[2]  = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd0};
    tbl[3]  = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd0};
    tbl[4]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 16'd1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd1};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[12] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[13] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[14] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[15] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 16'd1};
    tbl[16] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd1};
    tbl[17] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 16'd1};

    do_reset();
    chk("rst_valid", 32'(mb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_cnt", 32'(flit_cnt), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_drop", 32'(req_drop), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk_flit("rst_data", mb_data, '0);

    for (int v = 0; v < 18; v++) begin
      req_valid    = tbl[v].req;
      mb_valid_ack = tbl[v].ack;
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(mb_valid), 32'(tbl[v].exp_valid));
      chk($sformatf("vec%0d_ack", v), 32'(req_ack), 32'(tbl[v].exp_ack));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(tbl[v].exp_busy));
      chk($sformatf("vec%0d_gid", v), 32'(grant_id), 32'(tbl[v].exp_gid));
      chk($sformatf("vec%0d_cnt", v), 32'(flit_cnt), 32'(tbl[v].exp_cnt));
      if (tbl[v].exp_valid) chk_flit($sformatf("vec%0d_data", v), mb_data, flits[tbl[v].exp_gid]);
    end

    // asynchronous reset while in SEND: everything clears without an edge, no ack pulse
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(mb_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(flit_cnt), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk_flit("arst_data", mb_data, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_noack", 32'(req_ack), 32'd0);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    // payload must hold while the requester changes its data during SEND
    do_reset();
    req_valid = 4'b0010;
    tick();
    tick();
    hold_a = flits[1];
    chk_flit("hold_first", mb_data, hold_a);
    req_data[1] = pat_flit(8'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flit("hold_send", mb_data, hold_a);
    end
    mb_valid_ack = 1'b1;
    n = 0;
    while (req_ack == '0 && n < 10) begin tick(); n++; end
    chk("hold_ack", 32'(req_ack), 32'b0010);
    req_valid = '0;
    chk_flit("hold_ackcyc", mb_data, hold_a);
    mb_valid_ack = 1'b0;
    tick();
    chk_flit("hold_release", mb_data, hold_a);
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    chk("hold_idle", 32'(busy), 32'd0);
    req_data[1] = flits[1];

    // all four requesting continuously: strict rotation
    do_reset();
    req_valid = 4'b1111;
    serve(0, 1);
    serve(1, 2);
    serve(2, 3);
    serve(3, 4);
    serve(0, 5);
    req_valid = '0;
    tick();

`ifdef MB_TX_ARB_TIMEOUT_EN
    do_reset();
    req_valid = 4'b0001;
    n = 0;
    while (req_drop == '0 && n < 60) begin tick(); n++; end
    chk("to_drop", 32'(req_drop), 32'b0001);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_cnt", 32'(flit_cnt), 32'd0);
    chk("to_valid", 32'(mb_valid), 32'd0);
    chk("to_noack", 32'(req_ack), 32'd0);
    req_valid = 4'b0010;
    serve(1, 1);
    chk("to_sticky", 32'(err_timeout), 32'd1);
    req_valid = '0;
    tick();
`else
    chk("nto_err", 32'(err_timeout), 32'd0);
    chk("nto_drop", 32'(req_drop), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
